operand_fetch: RTL and testbench

Issue stage between decode and execute. Drives the register file read selects from the incoming instruction's source fields and captures both operands, with a same-cycle writeback bypass. A 32-bit scoreboard of pending destination writes stalls RAW and WAW hazards. Issue to execute is a single registered slot with valid/ready handshakes on both sides.

---
 rtl/operand_fetch.sv | 141 ++++++++++++++
 tb/tb_operand_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: issue stage between decode and execute.
// Drives register file read selects straight from the decoded source fields,
// captures both operands (with a same-cycle writeback bypass) into a single
// registered issue slot, and tracks pending destination writes in a 32-bit
// scoreboard so RAW and WAW hazards stall decode.
module operand_fetch (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_en,

    output logic [4:0]  o_selectA,
    output logic [4:0]  o_selectB,
    input  logic [31:0] i_portA,
    input  logic [31:0] i_portB,

    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_sel,
    input  logic [31:0] i_wb_data,

    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_opA,
    output logic [31:0] o_opB,
    output logic [4:0]  o_rd,
    output logic        o_rd_en,
    output logic        o_busy
);

    // Issue slot and scoreboard state
    logic        valid_q, valid_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_en_q, rd_en_d;
    logic [31:0] sb_q, sb_d;

    // Hazard / handshake terms
    logic hit_rs1, hit_rs2, hit_rd;
    logic raw_rs1, raw_rs2, waw;
    logic slot_free;
    logic accept;
    logic set_en;

    // Register file reads are combinational from the incoming source fields.
    assign o_selectA = i_rs1;
    assign o_selectB = i_rs2;

    // Bypass hits and hazard detection; a writeback landing this cycle
    // resolves the pending bit for the matching register.
    always_comb begin
        hit_rs1 = i_wb_en && (i_wb_sel == i_rs1) && (i_rs1 != 5'd0);
        hit_rs2 = i_wb_en && (i_wb_sel == i_rs2) && (i_rs2 != 5'd0);
        hit_rd  = i_wb_en && (i_wb_sel == i_rd)  && (i_rd  != 5'd0);
        raw_rs1 = (i_rs1 != 5'd0) && sb_q[i_rs1] && !hit_rs1;
        raw_rs2 = (i_rs2 != 5'd0) && sb_q[i_rs2] && !hit_rs2;
        waw     = i_rd_en && (i_rd != 5'd0) && sb_q[i_rd] && !hit_rd;
    end

    // Ready never looks at i_valid, so decode can rely on it without a loop.
    assign slot_free = !valid_q || i_ready;
    assign o_ready   = slot_free && !raw_rs1 && !raw_rs2 && !waw && !i_reset;
    assign accept    = i_valid && o_ready;
    assign set_en    = accept && i_rd_en && (i_rd != 5'd0);

    // Issue slot next state: load on accept, drop valid on a bare consume,
    // otherwise hold everything (covers downstream stalls).
    always_comb begin
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rd_d    = rd_q;
        rd_en_d = rd_en_q;
        if (accept) begin
            valid_d = 1'b1;
            if (i_rs1 == 5'd0) begin
                opa_d = 32'd0;
            end else if (hit_rs1) begin
                opa_d = i_wb_data;
            end else begin
                opa_d = i_portA;
            end
            if (i_rs2 == 5'd0) begin
                opb_d = 32'd0;
            end else if (hit_rs2) begin
                opb_d = i_wb_data;
            end else begin
                opb_d = i_portB;
            end
            rd_d    = i_rd;
            rd_en_d = i_rd_en;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so a
    // same-index collision leaves the bit pending. Bit 0 is never tracked.
    always_comb begin
        sb_d = sb_q;
        if (i_wb_en) begin
            sb_d[i_wb_sel] = 1'b0;
        end
        if (set_en) begin
            sb_d[i_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // State registers with asynchronous clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            rd_q    <= 5'd0;
            rd_en_q <= 1'b0;
            sb_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
            rd_en_q <= rd_en_d;
            sb_q    <= sb_d;
        end
    end

    assign o_valid = valid_q;
    assign o_opA   = opa_q;
    assign o_opB   = opb_q;
    assign o_rd    = rd_q;
    assign o_rd_en = rd_en_q;
    assign o_busy  = |sb_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, a reset
// sequence with pending state, and randomized traffic against a behavioural
// model (pending-register array plus slot contents).
module tb_operand_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic        i_rd_en;
    logic [4:0]  o_selectA, o_selectB;
    logic [31:0] i_portA, i_portB;
    logic        i_wb_en;
    logic [4:0]  i_wb_sel;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_opA, o_opB;
    logic [4:0]  o_rd;
    logic        o_rd_en;
    logic        o_busy;

    operand_fetch dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_rd      (i_rd),
        .i_rd_en   (i_rd_en),
        .o_selectA (o_selectA),
        .o_selectB (o_selectB),
        .i_portA   (i_portA),
        .i_portB   (i_portB),
        .i_wb_en   (i_wb_en),
        .i_wb_sel  (i_wb_sel),
        .i_wb_data (i_wb_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_opA     (o_opA),
        .o_opB     (o_opB),
        .o_rd      (o_rd),
        .o_rd_en   (o_rd_en),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_en;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        wb_en;
        logic [4:0]  wb_sel;
        logic [31:0] wb_data;
        logic        rdy;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_opA;
        logic [31:0] e_opB;
        logic [4:0]  e_rd;
        logic        e_rd_en;
        logic        e_busy;
    } vec_t;

    vec_t tbl[19];

    // Behavioural reference: which registers have a write outstanding, and
    // what the issue slot should currently hold.
    bit          pend[32];
    bit          m_valid;
    logic [31:0] m_opA, m_opB;
    logic [4:0]  m_rd;
    bit          m_rd_en;

    function automatic bit wb_hits(input logic [4:0] r);
        return i_wb_en && (i_wb_sel == r) && (r != 5'd0);
    endfunction

    function automatic bit blocked(input logic [4:0] r);
        return (r != 5'd0) && pend[r] && !wb_hits(r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = blocked(i_rs1) || blocked(i_rs2) || (i_rd_en && blocked(i_rd));
        return (!m_valid || i_ready) && !hz && !i_reset;
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] r, input logic [31:0] port);
        if (r == 5'd0) return 32'd0;
        if (wb_hits(r)) return i_wb_data;
        return port;
    endfunction

    function automatic bit m_busy();
        for (int k = 0; k < 32; k++) if (pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        i_valid = 1'b0; i_rs1 = 5'd0; i_rs2 = 5'd0; i_rd = 5'd0; i_rd_en = 1'b0;
        i_portA = 32'd0; i_portB = 32'd0;
        i_wb_en = 1'b0; i_wb_sel = 5'd0; i_wb_data = 32'd0; i_ready = 1'b1;
    endtask

    initial begin
        bit          acc;
        logic [31:0] na, nb;
        int          pick;

        i_reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_ready_low", {31'd0, o_ready}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        i_reset = 1'b0;

        // Reset while the slot is full and sb[5] is pending
        i_valid = 1'b1; i_rs1 = 5'd1; i_rs2 = 5'd2; i_rd = 5'd5; i_rd_en = 1'b1;
        i_portA = 32'h55; i_portB = 32'h66; i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        chk("pre_rst_opA", o_opA, 32'h55);
        #2;
        i_reset = 1'b1; i_wb_en = 1'b1; i_wb_sel = 5'd5; i_wb_data = 32'h1234;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
        chk("mid_rst_opA", o_opA, 32'd0);
        chk("mid_rst_opB", o_opB, 32'd0);
        chk("mid_rst_rd", {27'd0, o_rd}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        drive_idle();
        @(negedge i_clk);
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
        @(posedge i_clk); #1;

        // Directed vectors: one cycle each, sb empty and slot empty at entry
        //           v     rs1    rs2    rd     en    portA         portB         wb    sel    wb_data       rdy  | rdy   vld   opA           opB           rd     en    busy
        tbl[0]  = '{1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 32'h11,       32'h22,       1'b0, 5'd0,  32'h0,        1'b1,  1'b1, 1'b1, 32'h11,       32'h22,       5'd3,  1'b1, 1'b1};
        tbl[1]  = '{1'b1, 5'd3,  5'd0,  5'd4,  1'b0, 32'h99,       32'h0,        1'b0, 5'd0,  32'h0,        1'b1,  1'b0, 1'b0, 32'h11,       32'h22,       5'd3,  1'b1, 1'b1};
        tbl[2]  = '{1'b1, 5'd3,  5'd0,  5'd4,  1'b0, 32'h99,       32'h0,        1'b0, 5'd0,  32'h0,        1'b1,  1'b0, 1'b0, 32'h11,       32'h22,       5'd3,  1'b1, 1'b1};
        tbl[3]  = '{1'b1, 5'd3,  5'd0,  5'd4,  1'b0, 32'h99,       32'h0,        1'b1, 5'd3,  32'h33,       1'b1,  1'b1, 1'b1, 32'h33,       32'h0,        5'd4,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd0,  5'd0,  5'd3,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1,  1'b1, 1'b1, 32'h0,        32'h0,        5'd3,  1'b1, 1'b1};
        tbl[5]  = '{1'b1, 5'd3,  5'd3,  5'd5,  1'b0, 32'h0,        32'h0,        1'b1, 5'd3,  32'hDEADBEEF, 1'b1,  1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 5'd5,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 5'd0,  5'd0,  5'd7,  1'b1, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        1'b1,  1'b1, 1'b1, 32'h0,        32'h0,        5'd7,  1'b1, 1'b1};
        tbl[7]  = '{1'b1, 5'd1,  5'd2,  5'd7,  1'b1, 32'h1,        32'h2,        1'b0, 5'd0,  32'h0,        1'b1,  1'b0, 1'b0, 32'h0,        32'h0,        5'd7,  1'b1, 1'b1};
        tbl[8]  = '{1'b1, 5'd1,  5'd2,  5'd7,  1'b1, 32'h1,        32'h2,        1'b1, 5'd7,  32'h77,       1'b1,  1'b1, 1'b1, 32'h1,        32'h2,        5'd7,  1'b1, 1'b1};
        tbl[9]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 5'd0,  32'h5,        1'b1,  1'b1, 1'b0, 32'h1,        32'h2,        5'd7,  1'b1, 1'b1};
        tbl[10] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 5'd7,  32'h5,        1'b1,  1'b1, 1'b0, 32'h1,        32'h2,        5'd7,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 5'd1,  5'd2,  5'd8,  1'b1, 32'hA1,       32'hB2,       1'b0, 5'd0,  32'h0,        1'b1,  1'b1, 1'b1, 32'hA1,       32'hB2,       5'd8,  1'b1, 1'b1};
        tbl[12] = '{1'b1, 5'd4,  5'd5,  5'd9,  1'b1, 32'hC4,       32'hC5,       1'b0, 5'd0,  32'h0,        1'b0,  1'b0, 1'b1, 32'hA1,       32'hB2,       5'd8,  1'b1, 1'b1};
        tbl[13] = tbl[12];
        tbl[14] = tbl[12];
        tbl[15] = '{1'b1, 5'd4,  5'd5,  5'd9,  1'b1, 32'hC4,       32'hC5,       1'b0, 5'd0,  32'h0,        1'b1,  1'b1, 1'b1, 32'hC4,       32'hC5,       5'd9,  1'b1, 1'b1};
        tbl[16] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 32'h0,        32'h0,        1'b1, 5'd9,  32'h0,        1'b1,  1'b1, 1'b1, 32'h0,        32'h0,        5'd0,  1'b1, 1'b1};
        tbl[17] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 5'd8,  32'h0,        1'b1,  1'b1, 1'b0, 32'h0,        32'h0,        5'd0,  1'b1, 1'b0};
        tbl[18] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0,        32'h0,        1'b1, 5'd12, 32'h0,        1'b1,  1'b1, 1'b0, 32'h0,        32'h0,        5'd0,  1'b1, 1'b0};

        for (int k = 0; k < 19; k++) begin
            i_valid = tbl[k].v; i_rs1 = tbl[k].rs1; i_rs2 = tbl[k].rs2;
            i_rd = tbl[k].rd; i_rd_en = tbl[k].rd_en;
            i_portA = tbl[k].pa; i_portB = tbl[k].pb;
            i_wb_en = tbl[k].wb_en; i_wb_sel = tbl[k].wb_sel; i_wb_data = tbl[k].wb_data;
            i_ready = tbl[k].rdy;
            @(negedge i_clk);
            chk($sformatf("v%0d_ready", k), {31'd0, o_ready}, {31'd0, tbl[k].e_ready});
            chk($sformatf("v%0d_selA", k), {27'd0, o_selectA}, {27'd0, tbl[k].rs1});
            @(posedge i_clk); #1;
            chk($sformatf("v%0d_valid", k), {31'd0, o_valid}, {31'd0, tbl[k].e_valid});
            chk($sformatf("v%0d_opA", k), o_opA, tbl[k].e_opA);
            chk($sformatf("v%0d_opB", k), o_opB, tbl[k].e_opB);
            chk($sformatf("v%0d_rd", k), {27'd0, o_rd}, {27'd0, tbl[k].e_rd});
            chk($sformatf("v%0d_rd_en", k), {31'd0, o_rd_en}, {31'd0, tbl[k].e_rd_en});
            chk($sformatf("v%0d_busy", k), {31'd0, o_busy}, {31'd0, tbl[k].e_busy});
        end

        // Randomized traffic against the reference model
        i_reset = 1'b1;
        drive_idle();
        for (int k = 0; k < 32; k++) pend[k] = 1'b0;
        m_valid = 1'b0; m_opA = 32'd0; m_opB = 32'd0; m_rd = 5'd0; m_rd_en = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            i_valid   = ($urandom_range(3) != 0);
            i_rs1     = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            i_rs2     = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            i_rd      = 5'($urandom_range(0, 7));
            i_rd_en   = ($urandom_range(3) != 0);
            i_portA   = $urandom;
            i_portB   = $urandom;
            i_wb_en   = ($urandom_range(1) == 1);
            i_wb_data = $urandom;
            i_wb_sel  = 5'($urandom_range(0, 15));
            if ($urandom_range(3) != 0) begin
                pick = int'($urandom_range(0, 31));
                for (int k = 0; k < 32; k++) begin
                    if (pend[(pick + k) % 32]) begin
                        i_wb_sel = 5'((pick + k) % 32);
                        break;
                    end
                end
            end
            i_ready   = ($urandom_range(3) != 0);

            @(negedge i_clk);
            acc = i_valid && m_ready();
            chk("rnd_ready", {31'd0, o_ready}, {31'd0, m_ready()});
            chk("rnd_selB", {27'd0, o_selectB}, {27'd0, i_rs2});
            na = m_operand(i_rs1, i_portA);
            nb = m_operand(i_rs2, i_portB);
            if (acc) begin
                m_valid = 1'b1; m_opA = na; m_opB = nb; m_rd = i_rd; m_rd_en = i_rd_en;
            end else if (m_valid && i_ready) begin
                m_valid = 1'b0;
            end
            if (i_wb_en && i_wb_sel != 5'd0) pend[i_wb_sel] = 1'b0;
            if (acc && i_rd_en && i_rd != 5'd0) pend[i_rd] = 1'b1;

            @(posedge i_clk); #1;
            chk("rnd_valid", {31'd0, o_valid}, {31'd0, m_valid});
            chk("rnd_opA", o_opA, m_opA);
            chk("rnd_opB", o_opB, m_opB);
            chk("rnd_rd", {27'd0, o_rd}, {27'd0, m_rd});
            chk("rnd_rd_en", {31'd0, o_rd_en}, {31'd0, m_rd_en});
            chk("rnd_busy", {31'd0, o_busy}, {31'd0, m_busy()});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
